// File: rtl/rename_sequencer_if.sv
// Decode-lane rename request/response bundle.
// The decode side holds the master modport and the sequencer holds the slave.
interface rename_sequencer_if #(
    parameter int AW = 3,
    parameter int PW = 4
);
    logic          req0_valid;
    logic [AW-1:0] req0_arch;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_arch;
    logic          req1_ready;
    logic          rsp_valid;
    logic          rsp_lane;
    logic [PW-1:0] rsp_phys;
    logic [PW-1:0] rsp_old;

    modport master (
        output req0_valid, req0_arch, req1_valid, req1_arch,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_lane, rsp_phys, rsp_old
    );

    modport slave (
        input  req0_valid, req0_arch, req1_valid, req1_arch,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_lane, rsp_phys, rsp_old
    );
endinterface

// File: rtl/rename_sequencer.sv
// Shares the renamer write port between two decode lanes and
// retires displaced physical tags in program order.
module rename_sequencer #(
    parameter int ARCH_REGS = 8,
    parameter int PHYS_REGS = 16,
    parameter int RQ_DEPTH  = 8,
    parameter int INIT_FREE = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    rename_sequencer_if.slave              lanes,
    input  logic                           commit_valid,
    output logic                           commit_err,
    output logic [$clog2(ARCH_REGS):0]     ren_writein,
    output logic [$clog2(PHYS_REGS):0]     ren_retirein,
    input  logic [$clog2(PHYS_REGS)-1:0]   ren_writeout,
    input  logic [$clog2(PHYS_REGS)-1:0]   ren_oldwrite,
    output logic [$clog2(PHYS_REGS+1)-1:0] free_count,
    output logic                           stall
);
    localparam int PW = $clog2(PHYS_REGS);
    localparam int QW = $clog2(RQ_DEPTH);
    localparam int CW = QW + 1;
    localparam int FW = $clog2(PHYS_REGS + 1);

    logic          rr;
    logic          inflight;
    logic          lane_q;
    logic [PW-1:0] rq_mem [RQ_DEPTH];
    logic [QW-1:0] head;
    logic [QW-1:0] tail;
    logic [CW-1:0] rq_count;

    logic          any_req;
    logic          can_grant;
    logic          grant;
    logic          gnt_lane;
    logic          rq_empty;
    logic          pop;
    logic          take_bypass;
    logic          push_q;
    logic          pop_q;
    logic [PW-1:0] pop_tag;

    assign any_req   = lanes.req0_valid | lanes.req1_valid;
    assign can_grant = (free_count != '0) &&
                       ((rq_count + CW'(inflight)) < CW'(RQ_DEPTH));

    always_comb begin
        gnt_lane = 1'b0;
        case ({lanes.req1_valid, lanes.req0_valid})
            2'b11:   gnt_lane = rr;
            2'b10:   gnt_lane = 1'b1;
            default: gnt_lane = 1'b0;
        endcase
    end

    // Gating with rst keeps the write port quiet while reset is held.
    assign grant            = rst & can_grant & any_req;
    assign lanes.req0_ready = grant & ~gnt_lane;
    assign lanes.req1_ready = grant & gnt_lane;
    assign stall            = ~can_grant & any_req;
    assign ren_writein      = grant ?
        {(gnt_lane ? lanes.req1_arch : lanes.req0_arch), 1'b1} : '0;

    assign lanes.rsp_valid = inflight;
    assign lanes.rsp_lane  = lane_q;
    assign lanes.rsp_phys  = ren_writeout;
    assign lanes.rsp_old   = ren_oldwrite;

    // An empty queue can still retire the tag arriving this cycle.
    assign rq_empty    = (rq_count == '0);
    assign pop         = commit_valid & (~rq_empty | inflight);
    assign take_bypass = commit_valid & rq_empty & inflight;
    assign push_q      = inflight & ~take_bypass;
    assign pop_q       = pop & ~take_bypass;
    assign pop_tag     = rq_empty ? ren_oldwrite : rq_mem[head];

    always_ff @(posedge clk) begin
        if (push_q) begin
            rq_mem[tail] <= ren_oldwrite;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_count   <= FW'(INIT_FREE);
            rr           <= 1'b0;
            inflight     <= 1'b0;
            lane_q       <= 1'b0;
            head         <= '0;
            tail         <= '0;
            rq_count     <= '0;
            ren_retirein <= '0;
            commit_err   <= 1'b0;
        end else begin
            inflight <= grant;
            if (grant) begin
                lane_q <= gnt_lane;
            end
            if (grant && lanes.req0_valid && lanes.req1_valid) begin
                rr <= ~gnt_lane;
            end
            free_count <= free_count - FW'(grant) + FW'(pop);
            if (push_q) begin
                tail <= tail + 1'b1;
            end
            if (pop_q) begin
                head <= head + 1'b1;
            end
            rq_count     <= rq_count + CW'(push_q) - CW'(pop_q);
            ren_retirein <= pop ? {pop_tag, 1'b1} : '0;
            commit_err   <= commit_valid & ~pop;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        free_count <= FW'(PHYS_REGS));

endmodule

// File: tb/tb_rename_sequencer.sv
// Bench for rename_sequencer: vector table plus response/retire scoreboards,
// and a second instance with a larger free pool for queue-full cases.
module tb_rename_sequencer;
    logic clk;
    logic rst;

    rename_sequencer_if i0 ();
    rename_sequencer_if i1 ();

    logic       cm0, err0, st0;
    logic [3:0] w0;
    logic [4:0] ret0;
    logic [3:0] wo0, ow0;
    logic [4:0] fc0;

    logic       cm1, err1, st1;
    logic [3:0] w1;
    logic [4:0] ret1;
    logic [3:0] wo1, ow1;
    logic [4:0] fc1;

    rename_sequencer u0 (
        .clk(clk), .rst(rst), .lanes(i0),
        .commit_valid(cm0), .commit_err(err0),
        .ren_writein(w0), .ren_retirein(ret0),
        .ren_writeout(wo0), .ren_oldwrite(ow0),
        .free_count(fc0), .stall(st0)
    );

    rename_sequencer #(.INIT_FREE(16)) u1 (
        .clk(clk), .rst(rst), .lanes(i1),
        .commit_valid(cm1), .commit_err(err1),
        .ren_writein(w1), .ren_retirein(ret1),
        .ren_writeout(wo1), .ren_oldwrite(ow1),
        .free_count(fc1), .stall(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Renamer stand-in for u0: map table plus a wrapping allocator.
    logic [3:0] rmap [8];
    logic [3:0] rnext;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) rmap[i] <= 4'(i);
            rnext <= 4'd8;
            wo0   <= '0;
            ow0   <= '0;
        end else if (w0[0]) begin
            wo0            <= rnext;
            ow0            <= rmap[w0[3:1]];
            rmap[w0[3:1]]  <= rnext;
            rnext          <= rnext + 4'd1;
        end
    end

    // Renamer stand-in for u1: old tags count up from 3.
    logic [3:0] cnt1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt1 <= 4'd3;
            wo1  <= '0;
            ow1  <= '0;
        end else if (w1[0]) begin
            wo1  <= cnt1 + 4'd8;
            ow1  <= cnt1;
            cnt1 <= cnt1 + 4'd1;
        end
    end

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        else
            npass++;
    endtask

    typedef struct {
        logic       lane;
        logic [3:0] phys;
        logic [3:0] old;
    } rsp_t;

    rsp_t       sb [$];
    logic [3:0] rq [$];
    bit         pend;
    logic [3:0] pend_old;
    logic [3:0] pmap [8];
    logic [3:0] pnext;

    task automatic model_reset();
        sb.delete();
        rq.delete();
        pend = 0;
        pend_old = '0;
        for (int i = 0; i < 8; i++) pmap[i] = 4'(i);
        pnext = 4'd8;
    endtask

    typedef struct {
        logic       v0;
        logic [2:0] a0;
        logic       v1;
        logic [2:0] a1;
        logic       cm;
        logic       r0;
        logic       r1;
        logic [4:0] fc;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic v0, input logic [2:0] a0,
                       input logic v1, input logic [2:0] a1,
                       input logic cm, input logic r0, input logic r1,
                       input logic [4:0] fc);
        vec_t t;
        t.v0 = v0; t.a0 = a0; t.v1 = v1; t.a1 = a1;
        t.cm = cm; t.r0 = r0; t.r1 = r1; t.fc = fc;
        tbl.push_back(t);
    endtask

    task automatic cyc(input vec_t t);
        logic [3:0] exp_w;
        logic [3:0] ret;
        logic [2:0] arch;
        bit         has_ret;
        bit         has_err;
        bit         gnt;
        rsp_t       e;
        rsp_t       got;
        @(negedge clk);
        i0.req0_valid = t.v0;
        i0.req0_arch  = t.a0;
        i0.req1_valid = t.v1;
        i0.req1_arch  = t.a1;
        cm0 = t.cm;
        #1;
        chk("ready0", i0.req0_ready, t.r0);
        chk("ready1", i0.req1_ready, t.r1);
        exp_w = t.r0 ? {t.a0, 1'b1} : (t.r1 ? {t.a1, 1'b1} : 4'd0);
        chk("writein", w0, exp_w);
        chk("stall", st0, (t.v0 | t.v1) & ~(t.r0 | t.r1));
        has_ret = 0;
        has_err = 0;
        ret = '0;
        if (t.cm) begin
            if (rq.size() != 0) begin
                ret = rq.pop_front();
                has_ret = 1;
            end else if (pend) begin
                ret = pend_old;
                pend = 0;
                has_ret = 1;
            end else begin
                has_err = 1;
            end
        end
        if (pend) rq.push_back(pend_old);
        pend = 0;
        gnt = t.r0 | t.r1;
        if (gnt) begin
            arch = t.r1 ? t.a1 : t.a0;
            e.lane = t.r1;
            e.phys = pnext;
            e.old  = pmap[arch];
            pmap[arch] = pnext;
            pnext = pnext + 4'd1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", i0.rsp_valid, gnt);
        if (gnt && sb.size() != 0) begin
            got = sb.pop_front();
            chk("rsp_lane", i0.rsp_lane, got.lane);
            chk("rsp_phys", i0.rsp_phys, got.phys);
            chk("rsp_old", i0.rsp_old, got.old);
            pend = 1;
            pend_old = got.old;
        end
        chk("retirein", ret0, has_ret ? {ret, 1'b1} : 5'd0);
        chk("commit_err", err0, has_err);
        chk("free_count", fc0, t.fc);
    endtask

    task automatic cyc1(input logic v, input logic [2:0] a, input logic cm,
                        input logic er, input logic [4:0] efc,
                        input logic [4:0] eret);
        @(negedge clk);
        i1.req0_valid = v;
        i1.req0_arch  = a;
        cm1 = cm;
        #1;
        chk("u1_ready", i1.req0_ready, er);
        chk("u1_stall", st1, v & ~er);
        @(posedge clk);
        #1;
        chk("u1_free", fc1, efc);
        chk("u1_retire", ret1, eret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        idle = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0};

        add(1, 1, 0, 0, 0, 1, 0, 7);
        add(0, 0, 0, 0, 0, 0, 0, 7);
        add(1, 1, 1, 2, 0, 1, 0, 6);
        add(1, 1, 1, 2, 0, 0, 1, 5);
        add(1, 1, 1, 2, 0, 1, 0, 4);
        add(1, 1, 1, 2, 0, 0, 1, 3);
        add(0, 0, 1, 3, 0, 0, 1, 2);
        add(0, 0, 1, 4, 0, 0, 1, 1);
        add(0, 0, 1, 5, 0, 0, 1, 0);
        add(1, 6, 1, 7, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(1, 3, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, 1, 0, 0, 5'(k));
        add(0, 0, 0, 0, 1, 0, 0, 8);
        add(1, 4, 0, 0, 0, 1, 0, 7);
        add(0, 0, 0, 0, 1, 0, 0, 8);
        add(1, 5, 0, 0, 0, 1, 0, 7);
        add(1, 6, 0, 0, 1, 1, 0, 7);
        add(0, 0, 0, 0, 1, 0, 0, 8);
        add(1, 1, 1, 2, 0, 1, 0, 7);
        add(1, 1, 1, 2, 1, 0, 1, 7);
        add(0, 0, 0, 0, 1, 0, 0, 8);

        rst = 1'b0;
        i0.req0_valid = 1'b1; i0.req0_arch = 3'd1;
        i0.req1_valid = 1'b0; i0.req1_arch = 3'd0;
        i1.req0_valid = 1'b0; i1.req0_arch = 3'd0;
        i1.req1_valid = 1'b0; i1.req1_arch = 3'd0;
        cm0 = 1'b0;
        cm1 = 1'b0;
        model_reset();
        #3;
        chk("rst_ready0", i0.req0_ready, 1'b0);
        chk("rst_writein", w0, 4'd0);
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", i0.rsp_valid, 1'b0);
        chk("rst_free", fc0, 5'd8);
        chk("rst_retire", ret0, 5'd0);
        chk("rst_err", err0, 1'b0);
        chk("rst_free_u1", fc1, 5'd16);
        @(negedge clk);
        i0.req0_valid = 1'b0;
        rst = 1'b1;

        foreach (tbl[i]) cyc(tbl[i]);

        // Reset lands inside the grant cycle: no response may appear.
        @(negedge clk);
        i0.req0_valid = 1'b1;
        i0.req0_arch  = 3'd7;
        #1;
        chk("pre_rst_ready0", i0.req0_ready, 1'b1);
        rst = 1'b0;
        #1;
        chk("in_rst_ready0", i0.req0_ready, 1'b0);
        chk("in_rst_writein", w0, 4'd0);
        @(posedge clk);
        #1;
        chk("in_rst_rsp_valid", i0.rsp_valid, 1'b0);
        chk("in_rst_free", fc0, 5'd8);
        @(negedge clk);
        i0.req0_valid = 1'b0;
        rst = 1'b1;
        model_reset();

        // Reset right after the grant edge clears the in-flight rename.
        @(negedge clk);
        i0.req0_valid = 1'b1;
        i0.req0_arch  = 3'd0;
        #1;
        chk("flight_ready0", i0.req0_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("flight_rsp_valid", i0.rsp_valid, 1'b1);
        chk("flight_free", fc0, 5'd7);
        rst = 1'b0;
        #1;
        chk("async_rsp_valid", i0.rsp_valid, 1'b0);
        chk("async_free", fc0, 5'd8);
        i0.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle.cm = 1'b1; idle.fc = 5'd8;
        cyc(idle);
        idle.cm = 1'b0; idle.v0 = 1'b1; idle.a0 = 3'd2;
        idle.r0 = 1'b1; idle.fc = 5'd7;
        cyc(idle);
        @(negedge clk);
        i0.req0_valid = 1'b0;

        for (int k = 1; k <= 8; k++)
            cyc1(1'b1, 3'(k), 1'b0, 1'b1, 5'(16 - k), 5'd0);
        cyc1(1'b1, 3'd0, 1'b0, 1'b0, 5'd8, 5'd0);
        cyc1(1'b1, 3'd0, 1'b1, 1'b0, 5'd9, {4'd3, 1'b1});
        cyc1(1'b1, 3'd1, 1'b1, 1'b1, 5'd9, {4'd4, 1'b1});
        cyc1(1'b1, 3'd2, 1'b1, 1'b1, 5'd9, {4'd5, 1'b1});
        cyc1(1'b0, 3'd0, 1'b0, 1'b0, 5'd9, 5'd0);
        cyc1(1'b1, 3'd3, 1'b0, 1'b1, 5'd8, 5'd0);
        cyc1(1'b1, 3'd4, 1'b0, 1'b0, 5'd8, 5'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/rename_sequencer.md
Name: rename_sequencer

Overview:
- Front-end controller that shares the single write port of `renamer` between two decode lanes.
- Arbitrates lanes round-robin and drives `writein`. Captures `writeout`/`oldwrite` one cycle later and returns them to the winning lane.
- Queues displaced physical registers in program order. On commit, frees the oldest one through `retirein`.
- Tracks free physical registers and stalls lanes when none remain or the retire queue is full.

Parameters:
- ARCH_REGS, 8, architectural registers; 3-bit index.
- PHYS_REGS, 16, physical registers; 4-bit tag.
- RQ_DEPTH, 8, retire-queue entries; power of two.
- INIT_FREE, 8, free physical registers after reset (PHYS_REGS - ARCH_REGS).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req0_valid  in  1  lane 0 requests rename of a destination
- req0_arch  in  3  lane 0 architectural destination
- req0_ready  out  1  lane 0 granted this cycle (combinational)
- req1_valid  in  1  lane 1 request
- req1_arch  in  3  lane 1 architectural destination
- req1_ready  out  1  lane 1 granted this cycle (combinational)
- rsp_valid  out  1  rename result valid (registered)
- rsp_lane  out  1  lane that owns the result
- rsp_phys  out  4  new physical tag (renamer writeout)
- rsp_old  out  4  displaced physical tag (renamer oldwrite)
- commit_valid  in  1  oldest renamed instruction committed
- commit_err  out  1  pulse: commit while retire queue empty
- ren_writein  out  4  to renamer: {arch[2:0], valid}
- ren_retirein  out  5  to renamer: {phys[3:0], valid} (registered)
- ren_writeout  in  4  from renamer: new phys tag, valid the cycle after writein
- ren_oldwrite  in  4  from renamer: old phys tag, same timing
- free_count  out  5  free physical registers not yet granted
- stall  out  1  can_grant == 0 while any reqN_valid is high

Behaviour:
- Reset (rst low, async) forces the following state:
  - free_count = INIT_FREE; retire queue empty; rr pointer = lane 0; in-flight flag clear.
  - rsp_valid, commit_err, ren_retirein, ren_writein, req*_ready are all 0.
  - An in-flight rename is discarded with no rsp_valid.
- can_grant = (free_count != 0) && (rq_count + inflight < RQ_DEPTH).
- Arbitration, combinational, at most one grant per cycle:
  - Both lanes valid: grant the lane selected by rr; rr flips to the other lane at the edge.
  - One lane valid: grant it; rr unchanged.
  - can_grant == 0: no ready, ren_writein = 0.
- Grant cycle N:
  - ren_writein = {req_arch, 1}.
  - At edge N: free_count -1, inflight set, lane latched.
- Cycle N+1:
  - rsp_valid = 1, rsp_lane = latched lane, rsp_phys = ren_writeout, rsp_old = ren_oldwrite.
  - ren_oldwrite is pushed to the retire-queue tail at edge N+1.
  - Back-to-back grants are allowed, giving throughput 1/cycle.
- Commit at edge with commit_valid = 1 and queue non-empty:
  - Pop the head.
  - ren_retirein = {head, 1} for exactly the next cycle.
  - free_count +1 at the same edge.
- Commit with queue empty but a push this cycle: pop the pushed entry (write-first bypass). Otherwise ignore the commit and pulse commit_err for one cycle.
- Simultaneous grant and commit: free_count net unchanged. Simultaneous push and pop: rq_count unchanged.
- Pointers wrap modulo RQ_DEPTH.
- free_count saturates: never below 0 (guarded by can_grant), never above PHYS_REGS (assertion).
- Reset mid-operation clears everything above within the same cycle (async).

Test Plan:
- After reset release, lane 0 writes arch 1 → cycle 1: ren_writein = 4'b0011, req0_ready = 1. Cycle 2: rsp_valid = 1, rsp_lane = 0, rsp_phys = renamer writeout. free_count 8 → 7.
- Both lanes valid every cycle (arch 1 and arch 2) → grants alternate 0,1,0,1. Exactly one ren_writein per cycle. rsp_lane sequence matches grants.
- 8 consecutive grants with no commit → free_count = 0, stall = 1, req*_ready = 0. One commit_valid → next cycle ren_retirein = {first rsp_old, 1}, free_count = 1, and a grant follows.
- Fill queue with RQ_DEPTH = 8 while INIT_FREE is raised to 16 → 9th request blocked by queue full. A commit plus a grant in the same cycle leaves free_count and rq_count unchanged.
- commit_valid with empty queue → commit_err pulses 1 cycle; ren_retirein stays 0; free_count unchanged.
- Assert rst low between grant and response → rsp_valid never rises. free_count = 8, queue empty immediately.
